// File: rtl/pipelined_sad_add_tree_if.sv
// Handshake and data bundle for pipelined_sad_add_tree: beat input side,
// segment result output side. The master drives beats, the slave is the tree.
interface pipelined_sad_add_tree_if #(
    parameter int NUM_INPUTS        = 16,
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int OUT_WIDTH         = 14,
    parameter int CNT_WIDTH         = 8
);
    logic [ELEMENT_BIT_DEPTH*NUM_INPUTS-1:0] addend_array;
    logic                                    in_valid;
    logic                                    in_first;
    logic                                    in_last;
    logic                                    in_ready;
    logic [OUT_WIDTH-1:0]                    add;
    logic [CNT_WIDTH-1:0]                    add_count;
    logic                                    add_ovf;
    logic                                    out_valid;
    logic                                    out_ready;

    modport master (
        output addend_array, in_valid, in_first, in_last, out_ready,
        input  in_ready, add, add_count, add_ovf, out_valid
    );

    modport slave (
        input  addend_array, in_valid, in_first, in_last, out_ready,
        output in_ready, add, add_count, add_ovf, out_valid
    );
endinterface

// File: rtl/pipelined_sad_add_tree.sv
// Pipelined NUM_INPUTS-way adder tree with first/last segment accumulator.
// Define SAD_ADD_SATURATE_EN to make every adder clamp instead of wrap.
module pipelined_sad_add_tree #(
    parameter int NUM_INPUTS        = 16,
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int OUT_WIDTH         = 14,
    parameter int CNT_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    pipelined_sad_add_tree_if.slave      bus
);
    localparam int LEVELS = $clog2(NUM_INPUTS);
    localparam int NODES  = 2 * NUM_INPUTS - 1;
    localparam int ROOT   = NODES - 1;

    // Handshake: a beat moves on in_valid & in_ready, a result on out_valid &
    // out_ready. Only an untaken result stalls, and a stall freezes every
    // register, so in_ready = ~(out_valid & ~out_ready) with no skid buffer.

    // Tree nodes are stored level by level: level 0 (the registered inputs)
    // at [0 .. NUM_INPUTS-1], level s starting at level_base(s).
    logic [OUT_WIDTH-1:0] node_q [NODES];
    logic [OUT_WIDTH-1:0] node_d [NODES];
    logic [NODES-1:0]     novf_q;
    logic [NODES-1:0]     novf_d;
    logic [LEVELS:0]      vld_q;
    logic [LEVELS:0]      first_q;
    logic [LEVELS:0]      last_q;

    logic [OUT_WIDTH-1:0] acc_q, acc_d, add_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, add_count_q;
    logic                 acc_ovf_q, acc_ovf_d, add_ovf_q, out_valid_q;
    logic                 stall, accept;
    logic [OUT_WIDTH:0]   node_r, acc_r;

    function automatic int level_base(input int s);
        return 2 * NUM_INPUTS - ((2 * NUM_INPUTS) >> s);
    endfunction

    // Returns {overflow, sum}; overflow is the carry out, or the clamp event.
    function automatic logic [OUT_WIDTH:0] add_op(input logic [OUT_WIDTH-1:0] a,
                                                  input logic [OUT_WIDTH-1:0] b);
        logic [OUT_WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
`ifdef SAD_ADD_SATURATE_EN
        if (full[OUT_WIDTH]) full[OUT_WIDTH-1:0] = '1;
`endif
        return full;
    endfunction

    assign stall  = out_valid_q & ~bus.out_ready;
    assign accept = bus.in_valid & ~stall;

    always_comb begin
        node_d = node_q;
        novf_d = novf_q;
        node_r = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            node_d[i] = OUT_WIDTH'(bus.addend_array[i*ELEMENT_BIT_DEPTH +: ELEMENT_BIT_DEPTH]);
            novf_d[i] = 1'b0;
        end
        for (int s = 1; s <= LEVELS; s++) begin
            for (int i = 0; i < (NUM_INPUTS >> s); i++) begin
                node_r = add_op(node_q[level_base(s-1) + 2*i], node_q[level_base(s-1) + 2*i + 1]);
                node_d[level_base(s) + i] = node_r[OUT_WIDTH-1:0];
                novf_d[level_base(s) + i] = node_r[OUT_WIDTH]
                                          | novf_q[level_base(s-1) + 2*i]
                                          | novf_q[level_base(s-1) + 2*i + 1];
            end
        end
    end

    // A beat without first continues from whatever acc holds, even after last.
    always_comb begin
        acc_r = add_op(acc_q, node_q[ROOT]);
        if (first_q[LEVELS]) begin
            acc_d     = node_q[ROOT];
            cnt_d     = CNT_WIDTH'(1);
            acc_ovf_d = novf_q[ROOT];
        end else begin
            acc_d     = acc_r[OUT_WIDTH-1:0];
            cnt_d     = cnt_q + CNT_WIDTH'(1);
            acc_ovf_d = acc_ovf_q | novf_q[ROOT] | acc_r[OUT_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) node_q[i] <= '0;
            novf_q      <= '0;
            vld_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_ovf_q   <= 1'b0;
            add_q       <= '0;
            add_count_q <= '0;
            add_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            node_q  <= node_d;
            novf_q  <= novf_d;
            vld_q   <= {vld_q[LEVELS-1:0], accept};
            first_q <= {first_q[LEVELS-1:0], accept & bus.in_first};
            last_q  <= {last_q[LEVELS-1:0], accept & bus.in_last};
            // Not stalled means any presented result is being taken now.
            out_valid_q <= 1'b0;
            if (vld_q[LEVELS]) begin
                acc_q     <= acc_d;
                cnt_q     <= cnt_d;
                acc_ovf_q <= acc_ovf_d;
                if (last_q[LEVELS]) begin
                    add_q       <= acc_d;
                    add_count_q <= cnt_d;
                    add_ovf_q   <= acc_ovf_d;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.add       = add_q;
    assign bus.add_count = add_count_q;
    assign bus.add_ovf   = add_ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pipelined_sad_add_tree.sv
// Scoreboarded bench for pipelined_sad_add_tree: directed scenarios plus a
// randomized phase, checked against an arithmetic segment model.
module tb_pipelined_sad_add_tree;
    localparam int N      = 16;
    localparam int EW     = 14;
    localparam int OW     = 14;
    localparam int CW     = 8;
    localparam int LEVELS = 4;
    localparam int DW     = N * EW;
    localparam int EXP_W  = 1 + CW + OW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_sad_add_tree_if #(.NUM_INPUTS(N), .ELEMENT_BIT_DEPTH(EW),
                                .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus();

    pipelined_sad_add_tree #(.NUM_INPUTS(N), .ELEMENT_BIT_DEPTH(EW),
                             .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                checks = 0;
    int                errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    longint            seg_total = 0;
    int                seg_cnt = 0;
    logic              stalled_prev = 1'b0;
    logic [EXP_W-1:0]  held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Segment result from plain arithmetic: true total, then wrap or clamp.
    function automatic logic [EXP_W-1:0] seg_result(input longint total, input int cnt);
        logic          o;
        logic [OW-1:0] a;
        o = (total >= (longint'(1) << OW));
`ifdef SAD_ADD_SATURATE_EN
        a = o ? {OW{1'b1}} : OW'(total);
`else
        a = OW'(total);
`endif
        return {o, CW'(cnt), a};
    endfunction

    function automatic logic [DW-1:0] fill(input int unsigned v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*EW +: EW] = EW'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        int unsigned   hi;
        case ($urandom_range(0, 2))
            0:       hi = (1 << EW) - 1;
            1:       hi = 255;
            default: hi = 1023;
        endcase
        r = '0;
        for (int i = 0; i < N; i++) r[i*EW +: EW] = EW'($urandom_range(0, hi));
        return r;
    endfunction

    // Stimulus side of the scoreboard: every accepted beat updates the model.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            longint beat;
            beat = 0;
            for (int i = 0; i < N; i++) beat += longint'(bus.addend_array[i*EW +: EW]);
            if (bus.in_first) begin
                seg_total = beat;
                seg_cnt   = 1;
            end else begin
                seg_total += beat;
                seg_cnt   += 1;
            end
            if (bus.in_last) exp_q.push_back(seg_result(seg_total, seg_cnt));
        end
    end

    // Monitor: pops on every transferred result, checks stall behaviour.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("hold_valid", bus.out_valid, 1);
                if (bus.out_valid) check("hold_data", {bus.add_ovf, bus.add_count, bus.add}, held);
            end
            check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got add=%0d count=%0d with none expected at %0t",
                             bus.add, bus.add_count, $time);
                end else begin
                    logic [EXP_W-1:0] e;
                    e = exp_q.pop_front();
                    check("add", bus.add, e[OW-1:0]);
                    check("add_count", bus.add_count, e[OW +: CW]);
                    check("add_ovf", bus.add_ovf, e[EXP_W-1]);
                end
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held = {bus.add_ovf, bus.add_count, bus.add};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) step();
    endtask

    // Presents a beat and returns 1 ns after the edge that accepted it.
    task automatic drive_beat(input logic [DW-1:0] data, input logic f, input logic l);
        int n;
        bus.addend_array = data;
        bus.in_valid     = 1'b1;
        bus.in_first     = f;
        bus.in_last      = l;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
                break;
            end
            @(negedge clk);
        end
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_add"}, bus.add, 0);
        check({tag, "_add_count"}, bus.add_count, 0);
        check({tag, "_add_ovf"}, bus.add_ovf, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int lat;
        logic pending;

        rst = 1'b1;
        bus.addend_array = '0;
        bus.in_valid     = 1'b0;
        bus.in_first     = 1'b0;
        bus.in_last      = 1'b0;
        bus.out_ready    = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single beat, latency measured in edges after the accepting edge.
        drive_beat(fill(100), 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i - 1;
                break;
            end
        end
        check("latency", lat, LEVELS + 1);
        step();
        idle(4);

        // Four-beat segment.
        drive_beat(fill(1), 1'b1, 1'b0);
        drive_beat(fill(2), 1'b0, 1'b0);
        drive_beat(fill(3), 1'b0, 1'b0);
        drive_beat(fill(4), 1'b0, 1'b1);
        idle(10);

        // Backpressure: three single-beat segments, result held six cycles.
        bus.out_ready = 1'b0;
        drive_beat(fill(5), 1'b1, 1'b1);
        drive_beat(fill(6), 1'b1, 1'b1);
        drive_beat(fill(7), 1'b1, 1'b1);
        idle(0);
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        idle(6);
        bus.out_ready = 1'b1;
        idle(12);

        // Overflow on every level.
        drive_beat(fill((1 << EW) - 1), 1'b1, 1'b1);
        idle(10);

        // Count wrap: one segment of 260 beats.
        drive_beat(fill(1), 1'b1, 1'b0);
        for (int i = 1; i < 259; i++) drive_beat(fill(1), 1'b0, 1'b0);
        drive_beat(fill(1), 1'b0, 1'b1);
        idle(10);

        // Async reset with a taken result, an open segment and beats in flight.
        drive_beat(fill(3), 1'b1, 1'b0);
        drive_beat(fill(4), 1'b0, 1'b0);
        drive_beat(fill(5), 1'b0, 1'b1);
        drive_beat(fill(9), 1'b1, 1'b0);
        drive_beat(fill(9), 1'b0, 1'b0);
        drive_beat(fill(9), 1'b0, 1'b0);
        drive_beat(fill(9), 1'b0, 1'b0);
        drive_beat(fill(9), 1'b0, 1'b0);
        idle(1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        seg_total = 0;
        seg_cnt   = 0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        idle(12);
        drive_beat(fill(1), 1'b1, 1'b1);
        idle(10);

        // Bubbles with back-to-back segments of length 1 and 2.
        for (int r = 0; r < 3; r++) begin
            drive_beat(rand_data(), 1'b1, 1'b1);
            idle(1);
            drive_beat(rand_data(), 1'b1, 1'b0);
            idle(1);
            drive_beat(rand_data(), 1'b0, 1'b1);
            idle(1);
        end
        idle(10);

        // Randomized traffic and backpressure.
        pending = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.addend_array = rand_data();
                    bus.in_valid     = 1'b1;
                    bus.in_first     = ($urandom_range(0, 3) == 0);
                    bus.in_last      = ($urandom_range(0, 2) == 0);
                    pending          = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (pending && bus.in_ready) pending = 1'b0;
            step();
        end
        bus.out_ready = 1'b1;
        idle(1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        idle(5);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
